tetron_placer: RTL and testbench

Board-side consumer of the per-rotation block offsets produced by the tetromino shapers. Given an anchor cell and four signed (voffset, hoffset) pairs, it either checks the four target cells against the playfield RAM and reports a collision, or locks the piece by writing its colour into those cells. It sits between the game controller and the single-port playfield RAM.

---
 rtl/tetron_placer.sv | 110 +++++++++++
 tb/tb_tetron_placer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tetron_placer.sv
// tetron_placer: checks or locks a four-cell tetromino against the single-port playfield RAM
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready, req_lock   request handshake; 0 = collision check, 1 = lock write
//   anchor_row/col, blkN_v/hoffset  anchor cell and four signed cell offsets
//   piece_color                     colour written on lock
//   brd_addr/rd_data/wr_en/wr_data  playfield RAM port (read data one cycle after address)
//   done, collide                   completion pulse and check result
//   TETRON_PLACER_EARLY_ABORT_EN    finish a check at the first colliding cell
module tetron_placer #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ADDR_W  = 8,
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_lock,
  input  logic [4:0]         anchor_row,
  input  logic [4:0]         anchor_col,
  input  logic [4:0]         blk1_voffset,
  input  logic [4:0]         blk1_hoffset,
  input  logic [4:0]         blk2_voffset,
  input  logic [4:0]         blk2_hoffset,
  input  logic [4:0]         blk3_voffset,
  input  logic [4:0]         blk3_hoffset,
  input  logic [4:0]         blk4_voffset,
  input  logic [4:0]         blk4_hoffset,
  input  logic [COLOR_W-1:0] piece_color,
  output logic [ADDR_W-1:0]  brd_addr,
  input  logic [COLOR_W-1:0] brd_rd_data,
  output logic               brd_wr_en,
  output logic [COLOR_W-1:0] brd_wr_data,
  output logic               done,
  output logic               collide
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  state_t             state_q;
  logic [1:0]         idx_q;
  logic               lock_q;
  logic [4:0]         arow_q, acol_q;
  logic [4:0]         v_q [4];
  logic [4:0]         h_q [4];
  logic [COLOR_W-1:0] color_q;
  logic               pend_onb_q, pend_out_q, coll_q;
  logic [6:0]         row, col;
  logic               issue, above, outside, onboard, hit, abort;
  always_comb begin
    row     = {2'b00, arow_q} + {{2{v_q[idx_q][4]}}, v_q[idx_q]};
    col     = {2'b00, acol_q} + {{2{h_q[idx_q][4]}}, h_q[idx_q]};
    issue   = state_q == ISSUE;
    above   = row[6];
    outside = !above && (col[6] || col >= 7'(BOARD_W) || row >= 7'(BOARD_H));
    onboard = !above && !outside;
    // result of the cell issued in the previous cycle, now that its read data is back
    hit     = pend_out_q || (pend_onb_q && brd_rd_data != '0);
  end
`ifdef TETRON_PLACER_EARLY_ABORT_EN
  assign abort = hit;
`else
  assign abort = 1'b0;
`endif
  assign brd_addr    = (issue && onboard) ? ADDR_W'(32'(row) * BOARD_W + 32'(col)) : '0;
  assign brd_wr_en   = issue && lock_q && onboard;
  assign brd_wr_data = brd_wr_en ? color_q : '0;
  assign req_ready   = state_q == IDLE;
  assign done        = state_q == FINISH;
  assign collide     = coll_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lock_q     <= 1'b0;
      pend_onb_q <= 1'b0;
      pend_out_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      pend_onb_q <= issue && !lock_q && onboard;
      pend_out_q <= issue && !lock_q && outside;
      coll_q     <= coll_q | hit;
      case (state_q)
        IDLE: if (req_valid) begin
          lock_q  <= req_lock;
          arow_q  <= anchor_row;
          acol_q  <= anchor_col;
          v_q[0]  <= blk1_voffset;
          v_q[1]  <= blk2_voffset;
          v_q[2]  <= blk3_voffset;
          v_q[3]  <= blk4_voffset;
          h_q[0]  <= blk1_hoffset;
          h_q[1]  <= blk2_hoffset;
          h_q[2]  <= blk3_hoffset;
          h_q[3]  <= blk4_hoffset;
          color_q <= piece_color;
          idx_q   <= '0;
          coll_q  <= 1'b0;
          state_q <= ISSUE;
        end
        ISSUE: begin
          idx_q   <= idx_q + 2'd1;
          state_q <= abort ? FINISH : (idx_q != 2'd3) ? ISSUE : lock_q ? FINISH : DRAIN;
        end
        DRAIN:   state_q <= FINISH;
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tetron_placer.sv
// tb_tetron_placer: directed self-checking bench for tetron_placer
module tb_tetron_placer;
  logic       clk = 0, rst = 1, req_valid = 0, req_lock = 0;
  logic       req_ready, brd_wr_en, done, collide;
  logic [4:0] anchor_row = 0, anchor_col = 0;
  logic [4:0] v1 = 0, v2 = 0, v3 = 0, v4 = 0, h1 = 0, h2 = 0, h3 = 0, h4 = 0;
  logic [2:0] piece_color = 0, brd_rd_data, brd_wr_data;
  logic [7:0] brd_addr;
  logic [2:0] mem [256];
  logic       clr = 0, poke_en = 0;
  logic [7:0] poke_addr = 0;
  logic [2:0] poke_data = 0;
  int total = 0, passed = 0;
  logic [7:0] o_addr [9];
  logic [2:0] o_data [9];
  logic [8:0] o_we, o_done, o_rdy, o_col;

  tetron_placer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .anchor_row(anchor_row), .anchor_col(anchor_col),
    .blk1_voffset(v1), .blk1_hoffset(h1), .blk2_voffset(v2), .blk2_hoffset(h2),
    .blk3_voffset(v3), .blk3_hoffset(h3), .blk4_voffset(v4), .blk4_hoffset(h4),
    .piece_color(piece_color), .brd_addr(brd_addr), .brd_rd_data(brd_rd_data),
    .brd_wr_en(brd_wr_en), .brd_wr_data(brd_wr_data), .done(done), .collide(collide)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    brd_rd_data <= mem[brd_addr];
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= '0;
    else if (poke_en) mem[poke_addr] <= poke_data;
    else if (brd_wr_en) mem[brd_addr] <= brd_wr_data;
  end

  task automatic poke(input logic [7:0] a, input logic [2:0] d, input logic c);
    @(negedge clk);
    poke_addr = a; poke_data = d; poke_en = !c; clr = c;
    @(negedge clk);
    poke_en = 0; clr = 0;
  endtask

  task automatic run(input logic lk, input logic [4:0] ar, ac, input logic [19:0] vv, hh,
                     input logic [2:0] c);
    @(negedge clk);
    req_lock = lk; anchor_row = ar; anchor_col = ac; piece_color = c;
    {v4, v3, v2, v1} = vv; {h4, h3, h2, h1} = hh; req_valid = 1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL ready_at_accept got=%b exp=1", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 0; req_lock = !lk; anchor_row = ~ar; anchor_col = ~ac; piece_color = ~c;
    {v4, v3, v2, v1} = ~vv; {h4, h3, h2, h1} = ~hh;
    o_we = 0; o_done = 0; o_rdy = 0; o_col = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      o_addr[n] = brd_addr; o_data[n] = brd_wr_data; o_we[n] = brd_wr_en;
      o_done[n] = done; o_rdy[n] = req_ready; o_col[n] = collide;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total += 6;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else passed++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    if (collide !== 1'b0) $display("FAIL reset_collide got=%b exp=0", collide); else passed++;
    if (brd_wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b exp=0", brd_wr_en); else passed++;
    if (brd_addr !== 8'd0) $display("FAIL reset_addr got=%0d exp=0", brd_addr); else passed++;
    if (brd_wr_data !== 3'd0) $display("FAIL reset_wr_data got=%0d exp=0", brd_wr_data); else passed++;
  endtask

  task automatic test_check_empty;
    logic [7:0] ea [4] = '{8'd54, 8'd53, 8'd55, 8'd56};
    run(0, 5'd5, 5'd4, 20'd0, {5'd2, 5'd1, 5'h1F, 5'd0}, 3'd0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (o_addr[k+1] !== ea[k]) $display("FAIL check_addr%0d got=%0d exp=%0d", k, o_addr[k+1], ea[k]);
      else passed++;
    end
    total += 4;
    if (o_we !== 9'd0) $display("FAIL check_no_write got=%b exp=0", o_we); else passed++;
    if (o_done !== 9'd1 << 6) $display("FAIL check_done_time got=%b exp=%b", o_done, 9'd1 << 6); else passed++;
    if (o_col[6] !== 1'b0) $display("FAIL check_collide got=%b exp=0", o_col[6]); else passed++;
    if (o_rdy !== 9'b110000000) $display("FAIL check_ready got=%b exp=110000000", o_rdy); else passed++;
  endtask

  task automatic test_check_hit;
    int dn;
`ifdef TETRON_PLACER_EARLY_ABORT_EN
    dn = 5;
`else
    dn = 6;
`endif
    poke(8'd55, 3'd3, 0);
    run(0, 5'd5, 5'd4, 20'd0, {5'd2, 5'd1, 5'h1F, 5'd0}, 3'd0);
    total += 3;
    if (o_done !== 9'd1 << dn) $display("FAIL hit_done_time got=%b exp=%b", o_done, 9'd1 << dn); else passed++;
    if (o_col[dn] !== 1'b1) $display("FAIL hit_collide got=%b exp=1", o_col[dn]); else passed++;
    if (o_col[8] !== 1'b1) $display("FAIL hit_collide_held got=%b exp=1", o_col[8]); else passed++;
    poke(8'd0, 3'd0, 1);
  endtask

  task automatic test_outside;
    run(0, 5'd0, 5'd8, 20'd0, {5'd2, 5'h1F, 5'd1, 5'd0}, 3'd0);
    total += 4;
    if (o_addr[1] !== 8'd8) $display("FAIL outside_addr0 got=%0d exp=8", o_addr[1]); else passed++;
    if (o_addr[4] !== 8'd0) $display("FAIL outside_addr3 got=%0d exp=0", o_addr[4]); else passed++;
    if (o_done !== 9'd1 << 6) $display("FAIL outside_done_time got=%b exp=%b", o_done, 9'd1 << 6); else passed++;
    if (o_col[6] !== 1'b1) $display("FAIL outside_collide got=%b exp=1", o_col[6]); else passed++;
  endtask

  task automatic test_above;
    run(0, 5'd0, 5'd4, {5'd0, 5'h1F, 5'd0, 5'd0}, {5'h1F, 5'd0, 5'd1, 5'd0}, 3'd0);
    total += 4;
    if (o_addr[2] !== 8'd5) $display("FAIL above_addr1 got=%0d exp=5", o_addr[2]); else passed++;
    if (o_addr[3] !== 8'd0) $display("FAIL above_addr2 got=%0d exp=0", o_addr[3]); else passed++;
    if (o_done !== 9'd1 << 6) $display("FAIL above_done_time got=%b exp=%b", o_done, 9'd1 << 6); else passed++;
    if (o_col[6] !== 1'b0) $display("FAIL above_collide got=%b exp=0", o_col[6]); else passed++;
  endtask

  task automatic test_lock;
    run(1, 5'd19, 5'd0, 20'd0, {5'd3, 5'd2, 5'd1, 5'd0}, 3'd5);
    total += 4;
    if (o_we !== 9'b000011110) $display("FAIL lock_we got=%b exp=000011110", o_we); else passed++;
    if (o_done !== 9'd1 << 5) $display("FAIL lock_done_time got=%b exp=%b", o_done, 9'd1 << 5); else passed++;
    if (o_col[5] !== 1'b0) $display("FAIL lock_collide got=%b exp=0", o_col[5]); else passed++;
    if (o_rdy !== 9'b111000000) $display("FAIL lock_ready got=%b exp=111000000", o_rdy); else passed++;
    for (int k = 0; k < 4; k++) begin
      total += 3;
      if (o_addr[k+1] !== 8'(190 + k)) $display("FAIL lock_addr%0d got=%0d exp=%0d", k, o_addr[k+1], 190 + k); else passed++;
      if (o_data[k+1] !== 3'd5) $display("FAIL lock_data%0d got=%0d exp=5", k, o_data[k+1]); else passed++;
      if (mem[190 + k] !== 3'd5) $display("FAIL lock_mem%0d got=%0d exp=5", k, mem[190 + k]); else passed++;
    end
  endtask

  task automatic test_lock_then_check;
    run(0, 5'd19, 5'd1, 20'd0, {5'd0, 5'd0, 5'd0, 5'd0}, 3'd0);
    total++;
    if (o_col[8] !== 1'b1) $display("FAIL relock_collide got=%b exp=1", o_col[8]); else passed++;
    poke(8'd0, 3'd0, 1);
  endtask

  task automatic test_lock_above;
    run(1, 5'd0, 5'd2, {5'd0, 5'd0, 5'h1F, 5'd0}, {5'd2, 5'd1, 5'd0, 5'd0}, 3'd4);
    total += 3;
    if (o_we !== 9'b000011010) $display("FAIL lock_above_we got=%b exp=000011010", o_we); else passed++;
    if (o_addr[3] !== 8'd3) $display("FAIL lock_above_addr2 got=%0d exp=3", o_addr[3]); else passed++;
    if (mem[4] !== 3'd4) $display("FAIL lock_above_mem got=%0d exp=4", mem[4]); else passed++;
    poke(8'd0, 3'd0, 1);
  endtask

  task automatic test_rst_mid;
    logic seen_done;
    @(negedge clk);
    req_lock = 1; anchor_row = 5'd10; anchor_col = 5'd0; piece_color = 3'd6;
    {v4, v3, v2, v1} = 20'd0; {h4, h3, h2, h1} = {5'd3, 5'd2, 5'd1, 5'd0}; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    total += 4;
    if (brd_wr_en !== 1'b0) $display("FAIL rst_mid_wr_en got=%b exp=0", brd_wr_en); else passed++;
    if (brd_addr !== 8'd0) $display("FAIL rst_mid_addr got=%0d exp=0", brd_addr); else passed++;
    if (req_ready !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", req_ready); else passed++;
    if (done !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", done); else passed++;
    seen_done = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      seen_done |= done;
    end
    total += 3;
    if (seen_done !== 1'b0) $display("FAIL rst_mid_late_done got=%b exp=0", seen_done); else passed++;
    if (mem[100] !== 3'd6) $display("FAIL rst_mid_mem0 got=%0d exp=6", mem[100]); else passed++;
    if (mem[101] !== 3'd0) $display("FAIL rst_mid_mem1 got=%0d exp=0", mem[101]); else passed++;
  endtask

  initial begin
    clr = 1;
    repeat (2) @(posedge clk);
    test_reset;
    @(negedge clk);
    rst = 0; clr = 0;
    test_reset;
    test_check_empty;
    test_check_hit;
    test_outside;
    test_above;
    test_lock;
    test_lock_then_check;
    test_lock_above;
    test_rst_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
